// File: rtl/motor_ramp_controller.sv
// Brushless motor drive controller: ramps the duty cycle toward a commanded target,
// reverses through zero, and latches hall-sensor and stall faults.
module motor_ramp_controller #(
    parameter int DUTY_W       = 10,
    parameter int RAMP_DIV     = 1024,
    parameter int STALL_CYCLES = 1048576
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              cmd_valid,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              cmd_dir,
    input  logic [2:0]        h,
    input  logic              fault_clear,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              dir,
    output logic              drive_en,
    output logic [2:0]        state,
    output logic              hall_fault,
    output logic              stall_fault,
    output logic [15:0]       hall_edge_count
);

    localparam int PRE_W   = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);

    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(RAMP_DIV - 1);
    localparam logic [PRE_W-1:0]   PRE_ONE   = PRE_W'(1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);
    localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);
    localparam logic [DUTY_W-1:0]  DUTY_ONE  = DUTY_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        RUN   = 3'd2,
        DECEL = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                dir_q, dir_d;
    logic                hall_fault_q, hall_fault_d;
    logic                stall_fault_q, stall_fault_d;
    logic [15:0]         edge_cnt_q, edge_cnt_d;
    logic [DUTY_W-1:0]   tgt_duty_q, tgt_duty_d;
    logic                tgt_dir_q, tgt_dir_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic [2:0]          sync1_q, hs_q, hs_prev_q;
    logic [1:0]          fill_q, fill_d;

    logic tick;
    logic drive_active;
    logic hs_valid;
    logic hall_invalid;
    logic hall_change;
    logic stall_hit;

    // The synchronizer restarts at 000 after reset; hall checks wait until the
    // pipeline holds real samples so the reset value is never seen as a fault.
    always_comb begin
        fill_d       = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        hs_valid     = (hs_q != 3'b000) && (hs_q != 3'b111);
        hall_invalid = (fill_q >= 2'd2) && !hs_valid;
        hall_change  = (fill_q == 2'd3) && (hs_q != hs_prev_q);
        edge_cnt_d   = (hall_change && hs_valid) ? edge_cnt_q + 16'd1 : edge_cnt_q;
    end

    always_comb begin
        tick       = (presc_q == PRE_LAST);
        presc_d    = tick ? '0 : presc_q + PRE_ONE;
        tgt_duty_d = cmd_valid ? cmd_duty : tgt_duty_q;
        tgt_dir_d  = cmd_valid ? cmd_dir : tgt_dir_q;
    end

    assign drive_active = (state_q == RAMP) || (state_q == RUN) || (state_q == DECEL);

    always_comb begin
        stall_d = stall_q;
        if (hall_change || (duty_q == '0)) begin
            stall_d = '0;
        end else if (drive_active && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_ONE;
        end
        stall_hit = drive_active && (stall_d == STALL_MAX);
    end

    always_comb begin
        state_d       = state_q;
        duty_d        = duty_q;
        dir_d         = dir_q;
        hall_fault_d  = hall_fault_q;
        stall_fault_d = stall_fault_q;
        if (hall_invalid || stall_hit) begin
            state_d = FAULT;
            duty_d  = '0;
            if (hall_invalid) hall_fault_d = 1'b1;
            if (stall_hit)    stall_fault_d = 1'b1;
        end else if (state_q == FAULT) begin
            duty_d = '0;
            if (fault_clear) begin
                hall_fault_d  = 1'b0;
                stall_fault_d = 1'b0;
                state_d       = IDLE;
            end
        end else if (!enable && drive_active) begin
            state_d = IDLE;
            duty_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    duty_d = '0;
                    if (enable && (tgt_duty_q != '0)) begin
                        dir_d   = tgt_dir_q;
                        state_d = RAMP;
                    end
                end
                RAMP: begin
                    if (tgt_dir_q != dir_q) begin
                        state_d = DECEL;
                    end else if (duty_q == tgt_duty_q) begin
                        state_d = RUN;
                    end else if (tick) begin
                        duty_d = (duty_q < tgt_duty_q) ? duty_q + DUTY_ONE : duty_q - DUTY_ONE;
                        if (duty_d == tgt_duty_q) state_d = RUN;
                    end
                end
                RUN: begin
                    if (tgt_dir_q != dir_q) begin
                        state_d = DECEL;
                    end else if (tgt_duty_q != duty_q) begin
                        state_d = RAMP;
                    end
                end
                DECEL: begin
                    // Direction may only change once the bridge has coasted to zero.
                    if (duty_q == '0) begin
                        dir_d   = tgt_dir_q;
                        state_d = (tgt_duty_q == '0) ? IDLE : RAMP;
                    end else if (tick) begin
                        duty_d = duty_q - DUTY_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            duty_q        <= '0;
            dir_q         <= 1'b0;
            hall_fault_q  <= 1'b0;
            stall_fault_q <= 1'b0;
            edge_cnt_q    <= '0;
            tgt_duty_q    <= '0;
            tgt_dir_q     <= 1'b0;
            presc_q       <= '0;
            stall_q       <= '0;
            sync1_q       <= 3'b000;
            hs_q          <= 3'b000;
            hs_prev_q     <= 3'b000;
            fill_q        <= 2'd0;
        end else begin
            state_q       <= state_d;
            duty_q        <= duty_d;
            dir_q         <= dir_d;
            hall_fault_q  <= hall_fault_d;
            stall_fault_q <= stall_fault_d;
            edge_cnt_q    <= edge_cnt_d;
            tgt_duty_q    <= tgt_duty_d;
            tgt_dir_q     <= tgt_dir_d;
            presc_q       <= presc_d;
            stall_q       <= stall_d;
            sync1_q       <= h;
            hs_q          <= sync1_q;
            hs_prev_q     <= hs_q;
            fill_q        <= fill_d;
        end
    end

    assign duty_cycle      = duty_q;
    assign dir             = dir_q;
    assign drive_en        = drive_active;
    assign state           = state_q;
    assign hall_fault      = hall_fault_q;
    assign stall_fault     = stall_fault_q;
    assign hall_edge_count = edge_cnt_q;

endmodule

// File: tb/tb_motor_ramp_controller.sv
// Testbench for motor_ramp_controller: vector table for ramp/reversal, random
// command sequences against a settle-time model, and hand-written fault sequences.
module tb_motor_ramp_controller;

    localparam int DUTY_W = 10;
    localparam int RAMP_DIV = 4;
    localparam int STALL_CYCLES = 100;

    localparam logic [2:0] S_IDLE = 3'd0, S_RAMP = 3'd1, S_RUN = 3'd2, S_DECEL = 3'd3, S_FAULT = 3'd4;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              cmd_valid;
    logic [DUTY_W-1:0] cmd_duty;
    logic              cmd_dir;
    logic [2:0]        h;
    logic              fault_clear;
    logic [DUTY_W-1:0] duty_cycle;
    logic              dir;
    logic              drive_en;
    logic [2:0]        state;
    logic              hall_fault;
    logic              stall_fault;
    logic [15:0]       hall_edge_count;

    motor_ramp_controller #(
        .DUTY_W(DUTY_W), .RAMP_DIV(RAMP_DIV), .STALL_CYCLES(STALL_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .cmd_valid(cmd_valid),
        .cmd_duty(cmd_duty), .cmd_dir(cmd_dir), .h(h), .fault_clear(fault_clear),
        .duty_cycle(duty_cycle), .dir(dir), .drive_en(drive_en), .state(state),
        .hall_fault(hall_fault), .stall_fault(stall_fault), .hall_edge_count(hall_edge_count)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_edges = 16'd0;
    logic [2:0]  hall_seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    int rot_idx = 0;
    int rot_phase = 0;
    int rot_period = 3;
    bit rotate = 1'b0;

    typedef struct {
        logic              send;
        logic [DUTY_W-1:0] cduty;
        logic              cdir;
        logic [DUTY_W-1:0] exp_duty;
        logic [2:0]        exp_state;
        logic              exp_dir;
        int                exp_gap;
    } vec_t;
    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every change of h to a valid code is one expected hall edge.
    task automatic set_h(input logic [2:0] v);
        if (v != h) begin
            if (v != 3'b000 && v != 3'b111) exp_edges = exp_edges + 16'd1;
            h = v;
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        if (rotate) begin
            rot_phase++;
            if (rot_phase >= rot_period) begin
                rot_phase = 0;
                rot_idx = (rot_idx + 1) % 6;
                set_h(hall_seq[rot_idx]);
            end
        end
    endtask

    task automatic send_cmd(input int d, input logic dr);
        cmd_valid = 1'b1;
        cmd_duty = DUTY_W'(d);
        cmd_dir = dr;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_duty(input int d, input int max, output int n);
        n = 0;
        while (duty_cycle != DUTY_W'(d) && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic check_edges(input string name);
        bit was = rotate;
        rotate = 1'b0;
        repeat (4) step();
        chk(name, 32'(hall_edge_count), 32'(exp_edges));
        $display("[TB] %s: hall_edge_count=0x%0h", name, hall_edge_count);
        rotate = was;
    endtask

    initial begin
        int n, cur_d, nd, ticks, budget, max_step, min_gap, last_chg, dlt;
        logic cur_dir, ndir, dir_ok;
        logic [DUTY_W-1:0] prev_duty;
        logic prev_dir;

        vecs[0]  = '{1'b1, 10'd5, 1'b0, 10'd1, S_RAMP,  1'b0, 0};
        vecs[1]  = '{1'b0, 10'd0, 1'b0, 10'd2, S_RAMP,  1'b0, 4};
        vecs[2]  = '{1'b0, 10'd0, 1'b0, 10'd3, S_RAMP,  1'b0, 4};
        vecs[3]  = '{1'b0, 10'd0, 1'b0, 10'd4, S_RAMP,  1'b0, 4};
        vecs[4]  = '{1'b0, 10'd0, 1'b0, 10'd5, S_RUN,   1'b0, 4};
        vecs[5]  = '{1'b1, 10'd3, 1'b1, 10'd4, S_DECEL, 1'b0, 0};
        vecs[6]  = '{1'b0, 10'd0, 1'b0, 10'd3, S_DECEL, 1'b0, 4};
        vecs[7]  = '{1'b0, 10'd0, 1'b0, 10'd2, S_DECEL, 1'b0, 4};
        vecs[8]  = '{1'b0, 10'd0, 1'b0, 10'd1, S_DECEL, 1'b0, 4};
        vecs[9]  = '{1'b0, 10'd0, 1'b0, 10'd0, S_DECEL, 1'b0, 4};
        vecs[10] = '{1'b0, 10'd0, 1'b0, 10'd1, S_RAMP,  1'b1, 0};
        vecs[11] = '{1'b0, 10'd0, 1'b0, 10'd2, S_RAMP,  1'b1, 4};
        vecs[12] = '{1'b0, 10'd0, 1'b0, 10'd3, S_RUN,   1'b1, 4};

        reset = 1'b1; enable = 1'b0; cmd_valid = 1'b0; cmd_duty = '0; cmd_dir = 1'b0;
        h = hall_seq[0]; fault_clear = 1'b0;
        #12;
        chk("rst_duty", 32'(duty_cycle), 0);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_drive_en", 32'(drive_en), 0);
        chk("rst_faults", 32'({hall_fault, stall_fault}), 0);
        chk("rst_edges", 32'(hall_edge_count), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) step();

        // Ramp-up and reversal, driven from the vector table.
        enable = 1'b1;
        rotate = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].send) send_cmd(int'(vecs[i].cduty), vecs[i].cdir);
            wait_duty(int'(vecs[i].exp_duty), 40, n);
            $display("[TB] vec %0d: duty=%0d state=%0d dir=%0d gap=%0d", i, duty_cycle, state, dir, n);
            chk($sformatf("vec%0d_duty", i), 32'(duty_cycle), 32'(vecs[i].exp_duty));
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            chk($sformatf("vec%0d_dir", i), 32'(dir), 32'(vecs[i].exp_dir));
            chk($sformatf("vec%0d_drive_en", i), 32'(drive_en), 1);
            if (vecs[i].exp_gap != 0) chk($sformatf("vec%0d_gap", i), 32'(n), 32'(vecs[i].exp_gap));
        end
        check_edges("edges_after_table");

        // Random commands: settle time is bounded by the number of one-LSB steps needed
        // (through zero on reversal), duty moves by at most one LSB per tick period,
        // and direction only flips while duty is zero.
        cur_d = 3;
        cur_dir = 1'b1;
        for (int k = 0; k < 20; k++) begin
            nd = int'($urandom_range(12, 1));
            ndir = 1'($urandom_range(1, 0));
            if (nd == cur_d && ndir == cur_dir) nd = nd % 12 + 1;
            if (ndir == cur_dir) ticks = (nd > cur_d) ? nd - cur_d : cur_d - nd;
            else ticks = cur_d + nd;
            budget = ticks * RAMP_DIV + 8;
            prev_duty = duty_cycle;
            prev_dir = dir;
            max_step = 0; min_gap = 1000; last_chg = -1; dir_ok = 1'b1;
            send_cmd(nd, ndir);
            n = 1;
            while (!(state == S_RUN && duty_cycle == DUTY_W'(nd) && dir == ndir) && n <= budget) begin
                if (duty_cycle != prev_duty) begin
                    dlt = (duty_cycle > prev_duty) ? int'(duty_cycle - prev_duty) : int'(prev_duty - duty_cycle);
                    if (dlt > max_step) max_step = dlt;
                    if (last_chg >= 0 && n - last_chg < min_gap) min_gap = n - last_chg;
                    last_chg = n;
                end
                if (dir != prev_dir && duty_cycle != '0) dir_ok = 1'b0;
                prev_duty = duty_cycle;
                prev_dir = dir;
                step();
                n++;
            end
            $display("[TB] rnd %0d: cmd %0d/%0d from %0d/%0d settled in %0d (budget %0d) duty=%0d dir=%0d",
                     k, nd, ndir, cur_d, cur_dir, n, budget, duty_cycle, dir);
            chk($sformatf("rnd%0d_settled", k), 32'(n <= budget), 1);
            chk($sformatf("rnd%0d_duty", k), 32'(duty_cycle), 32'(nd));
            chk($sformatf("rnd%0d_dir", k), 32'(dir), 32'(ndir));
            chk($sformatf("rnd%0d_max_step", k), 32'(max_step <= 1), 1);
            chk($sformatf("rnd%0d_min_gap", k), 32'(min_gap >= RAMP_DIV), 1);
            chk($sformatf("rnd%0d_dir_at_zero", k), 32'(dir_ok), 1);
            cur_d = nd;
            cur_dir = ndir;
        end
        check_edges("edges_after_random");

        // Enable drop from RUN, then mid-ramp at duty 4.
        enable = 1'b0;
        step();
        chk("endrop_run_duty", 32'(duty_cycle), 0);
        chk("endrop_run_state", 32'(state), 32'(S_IDLE));
        enable = 1'b1;
        send_cmd(8, 1'b0);
        wait_duty(4, 40, n);
        chk("endrop_pre_state", 32'(state), 32'(S_RAMP));
        enable = 1'b0;
        step();
        $display("[TB] enable drop: duty=%0d state=%0d drive_en=%0d", duty_cycle, state, drive_en);
        chk("endrop_duty", 32'(duty_cycle), 0);
        chk("endrop_state", 32'(state), 32'(S_IDLE));
        chk("endrop_drive_en", 32'(drive_en), 0);

        // Stall: hall frozen at 101 while driving duty 5.
        enable = 1'b1;
        send_cmd(5, 1'b0);
        wait_duty(5, 60, n);
        chk("stall_pre_state", 32'(state), 32'(S_RUN));
        rotate = 1'b0;
        set_h(3'b100);
        step();
        set_h(3'b101);
        n = 0;
        while (state != S_FAULT && n < 200) begin
            step();
            n++;
        end
        $display("[TB] stall: fault after %0d clocks, stall_fault=%0d duty=%0d", n, stall_fault, duty_cycle);
        chk("stall_time", 32'(n >= STALL_CYCLES && n <= STALL_CYCLES + 6), 1);
        chk("stall_flag", 32'(stall_fault), 1);
        chk("stall_hall_flag", 32'(hall_fault), 0);
        chk("stall_duty", 32'(duty_cycle), 0);
        chk("stall_drive_en", 32'(drive_en), 0);
        enable = 1'b0;
        step();
        chk("stall_hold_state", 32'(state), 32'(S_FAULT));
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        chk("stall_clr_state", 32'(state), 32'(S_IDLE));
        chk("stall_clr_flags", 32'({hall_fault, stall_fault}), 0);

        // Invalid hall code during RUN.
        enable = 1'b1;
        rotate = 1'b1;
        send_cmd(5, 1'b0);
        wait_duty(5, 60, n);
        chk("hall_pre_state", 32'(state), 32'(S_RUN));
        rotate = 1'b0;
        set_h(3'b111);
        step();
        chk("hall_clk1_state", 32'(state), 32'(S_RUN));
        step();
        chk("hall_clk2_state", 32'(state), 32'(S_RUN));
        step();
        $display("[TB] invalid hall: state=%0d hall_fault=%0d duty=%0d", state, hall_fault, duty_cycle);
        chk("hall_state", 32'(state), 32'(S_FAULT));
        chk("hall_flag", 32'(hall_fault), 1);
        chk("hall_duty", 32'(duty_cycle), 0);
        enable = 1'b0;
        set_h(3'b001);
        repeat (3) step();
        set_h(3'b000);
        repeat (2) step();
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        chk("hall_clr_vs_fault_state", 32'(state), 32'(S_FAULT));
        chk("hall_clr_vs_fault_flag", 32'(hall_fault), 1);
        set_h(3'b001);
        repeat (3) step();
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        chk("hall_clr_state", 32'(state), 32'(S_IDLE));
        chk("hall_clr_flag", 32'(hall_fault), 0);
        check_edges("edges_after_faults");

        // Asynchronous reset in the middle of a ramp.
        enable = 1'b1;
        rotate = 1'b1;
        send_cmd(8, 1'b1);
        wait_duty(2, 40, n);
        chk("arst_pre_state", 32'(state), 32'(S_RAMP));
        chk("arst_pre_dir", 32'(dir), 1);
        rotate = 1'b0;
        reset = 1'b1;
        exp_edges = 16'd0;
        #1;
        $display("[TB] async reset: duty=%0d state=%0d dir=%0d drive_en=%0d edges=%0d",
                 duty_cycle, state, dir, drive_en, hall_edge_count);
        chk("arst_duty", 32'(duty_cycle), 0);
        chk("arst_state", 32'(state), 32'(S_IDLE));
        chk("arst_dir", 32'(dir), 0);
        chk("arst_drive_en", 32'(drive_en), 0);
        chk("arst_edges", 32'(hall_edge_count), 0);
        @(negedge clock);
        enable = 1'b0;
        reset = 1'b0;
        repeat (4) step();

        // Hall edge counter wrap, one hall change per clock while idle.
        rot_period = 1;
        rotate = 1'b1;
        repeat (65533) step();
        check_edges("edges_near_wrap");
        chk("edges_near_wrap_const", 32'(hall_edge_count), 32'h0000_FFFD);
        rotate = 1'b1;
        repeat (3) step();
        check_edges("edges_wrapped");
        chk("edges_wrapped_const", 32'(hall_edge_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
